// File: rtl/truth_table_sequencer_pkg.sv
// truth_table_sequencer_pkg: shared state encoding and sweep geometry
package truth_table_sequencer_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, DONE = 2'd2} state_t;
  localparam int TT_IDX_W = 4;
  localparam int TT_NVEC = 16;
  localparam int DWELL_W = 8;
endpackage

// File: rtl/truth_table_sequencer_dwell_timer.sv
// dwell_timer: counts hold cycles, tick marks the last cycle of each hold
module dwell_timer
  import truth_table_sequencer_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);
  logic [DWELL_W-1:0] cnt;
  assign tick = cnt == DWELL_W'(DWELL - 1);
  always_ff @(posedge clk) begin
    if (!rst_n || clear) cnt <= '0;
    else if (enable) cnt <= tick ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer: sweeps all 16 input codes and checks outputs against golden columns
module truth_table_sequencer
  import truth_table_sequencer_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] exp_alpha,
  input  logic [15:0] exp_beta,
  input  logic [15:0] exp_gamma,
  input  logic        F_alpha,
  input  logic        F_beta,
  input  logic        F_gamma,
  output logic        A,
  output logic        B,
  output logic        C,
  output logic        D,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  mismatch_count,
  output logic [3:0]  first_fail_idx,
  output logic        first_fail_valid,
  output logic [15:0] res_alpha,
  output logic [15:0] res_beta,
  output logic [15:0] res_gamma
);
  state_t state, nxt;
  logic [TT_IDX_W-1:0] idx;
  logic [15:0] gold_alpha, gold_beta, gold_gamma;
  logic tick, sample, miss, last;
  dwell_timer #(.DWELL(DWELL)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .clear(state != DRIVE),
    .enable(state == DRIVE),
    .tick(tick)
  );
  assign {A, B, C, D} = idx;
  assign busy = state == DRIVE;
  assign done = state == DONE;
  assign last = idx == TT_IDX_W'(TT_NVEC - 1);
  assign sample = busy && tick && !abort;
  assign miss = {F_alpha, F_beta, F_gamma} != {gold_alpha[idx], gold_beta[idx], gold_gamma[idx]};
  always_comb begin
    nxt = IDLE;
    if (state == IDLE) nxt = start ? DRIVE : IDLE;
    else if (state == DRIVE) nxt = abort ? IDLE : (sample && last) ? DONE : DRIVE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      gold_alpha <= '0;
      gold_beta <= '0;
      gold_gamma <= '0;
      res_alpha <= '0;
      res_beta <= '0;
      res_gamma <= '0;
      mismatch_count <= '0;
      first_fail_idx <= '0;
      first_fail_valid <= 1'b0;
      pass <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && start) begin
        gold_alpha <= exp_alpha;
        gold_beta <= exp_beta;
        gold_gamma <= exp_gamma;
        res_alpha <= '0;
        res_beta <= '0;
        res_gamma <= '0;
        mismatch_count <= '0;
        first_fail_idx <= '0;
        first_fail_valid <= 1'b0;
        pass <= 1'b0;
        idx <= '0;
      end
      if (busy && abort) idx <= '0;
      if (sample) begin
        res_alpha[idx] <= F_alpha;
        res_beta[idx] <= F_beta;
        res_gamma[idx] <= F_gamma;
        if (miss) begin
          mismatch_count <= mismatch_count + 1'b1;
          if (!first_fail_valid) begin
            first_fail_idx <= idx;
            first_fail_valid <= 1'b1;
          end
        end
        idx <= last ? '0 : idx + 1'b1;
        if (last) pass <= mismatch_count == '0 && !miss;
      end
    end
  end
endmodule

// File: tb/tb_truth_table_sequencer.sv
// tb_truth_table_sequencer: randomized sweeps scored against a truth-table reference model
module tb_truth_table_sequencer;
  localparam int DWELL = 4;
  logic clk = 0, rst_n = 0, start = 0, abort = 0;
  logic [15:0] exp_alpha = 0, exp_beta = 0, exp_gamma = 0;
  logic [15:0] ua = 0, ub = 0, ug = 0;
  logic F_alpha, F_beta, F_gamma, A, B, C, D, busy, done, pass, first_fail_valid;
  logic [4:0] mismatch_count;
  logic [3:0] first_fail_idx;
  logic [15:0] res_alpha, res_beta, res_gamma;
  int total = 0, bad = 0, cyc = 0, done_seen = 0, k = 0;
  typedef struct {
    logic [15:0] ra, rb, rg;
    logic [4:0] cnt;
    logic [3:0] ffi;
    logic ffv, pass;
    int dc;
  } exp_t;
  exp_t sb[$];
  exp_t m;
  truth_table_sequencer #(.DWELL(DWELL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .exp_alpha(exp_alpha), .exp_beta(exp_beta), .exp_gamma(exp_gamma),
    .F_alpha(F_alpha), .F_beta(F_beta), .F_gamma(F_gamma),
    .A(A), .B(B), .C(C), .D(D), .busy(busy), .done(done), .pass(pass),
    .mismatch_count(mismatch_count), .first_fail_idx(first_fail_idx),
    .first_fail_valid(first_fail_valid),
    .res_alpha(res_alpha), .res_beta(res_beta), .res_gamma(res_gamma)
  );
  assign F_alpha = ua[{A, B, C, D}];
  assign F_beta = ub[{A, B, C, D}];
  assign F_gamma = ug[{A, B, C, D}];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask
  // Expected results for the first nvec codes of a sweep started at edge ks
  function automatic exp_t model(logic [15:0] ea, eb, eg, int nvec, int ks);
    exp_t e;
    e = '{default: 0};
    for (int i = 0; i < nvec; i++) begin
      e.ra[i] = ua[i];
      e.rb[i] = ub[i];
      e.rg[i] = ug[i];
      if ({ua[i], ub[i], ug[i]} != {ea[i], eb[i], eg[i]}) begin
        if (!e.ffv) begin
          e.ffi = 4'(i);
          e.ffv = 1;
        end
        e.cnt++;
      end
    end
    e.pass = nvec == 16 && e.cnt == 0;
    e.dc = ks + 16 * DWELL;
    return e;
  endfunction
  always @(negedge clk) begin
    if (done) begin
      done_seen++;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done: got done=1 want no done at cycle %0d", cyc);
      end else begin
        bad--;
        total--;
        m = sb.pop_front();
        chk("done_cycle", cyc, m.dc);
        chk("res_alpha", res_alpha, m.ra);
        chk("res_beta", res_beta, m.rb);
        chk("res_gamma", res_gamma, m.rg);
        chk("mismatch_count", mismatch_count, m.cnt);
        chk("first_fail_valid", first_fail_valid, m.ffv);
        if (m.ffv) chk("first_fail_idx", first_fail_idx, m.ffi);
        chk("pass", pass, m.pass);
        bad++;
      end
    end
  end
  task automatic start_sweep(input logic [15:0] ea, eb, eg, input bit push);
    @(negedge clk);
    exp_alpha = ea;
    exp_beta = eb;
    exp_gamma = eg;
    start = 1;
    abort = 0;
    @(posedge clk);
    #1;
    k = cyc;
    start = 0;
    if (push) sb.push_back(model(ea, eb, eg, 16, k));
    exp_alpha = 16'($urandom);
    exp_beta = 16'($urandom);
    exp_gamma = 16'($urandom);
  endtask
  task automatic full_sweep(input logic [15:0] ea, eb, eg);
    int ds;
    ds = done_seen;
    start_sweep(ea, eb, eg, 1);
    for (int j = 0; j < 16 * DWELL; j++) begin
      @(negedge clk);
      chk("busy_drive", busy, 1);
      chk("abcd_drive", {A, B, C, D}, j / DWELL);
      start = j == 20;
    end
    start = 0;
    @(negedge clk);
    @(negedge clk);
    chk("done_once", done_seen - ds, 1);
    chk("busy_idle", busy, 0);
    chk("abcd_idle", {A, B, C, D}, 0);
  endtask
  task automatic rand_unit(output logic [15:0] ea, eb, eg);
    logic [15:0] fl;
    ua = 16'($urandom);
    ub = 16'($urandom);
    ug = 16'($urandom);
    fl = ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom & $urandom & $urandom);
    ea = ua ^ fl;
    eb = ub ^ (16'($urandom & $urandom & $urandom) & {16{fl != 0}});
    eg = ug;
  endtask
  initial begin
    logic [15:0] ea, eb, eg;
    int ds;
    ua = 16'hAAAA;
    ub = 16'h8888;
    ug = 16'hFFF0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_abcd", {A, B, C, D}, 0);
    chk("rst_count", mismatch_count, 0);
    chk("rst_res", {res_alpha, res_beta}, 0);
    rst_n = 1;
    full_sweep(16'hAAAA, 16'h8888, 16'hFFF0);
    full_sweep(16'hAAAA, 16'h8808, 16'hFFF0);
    for (int t = 0; t < 5; t++) begin
      rand_unit(ea, eb, eg);
      full_sweep(ea, eb, eg);
    end
    rand_unit(ea, eb, eg);
    start_sweep(ea, eb, eg, 0);
    for (int j = 0; j < 6 * DWELL; j++) @(negedge clk);
    chk("abort_at_idx5", {A, B, C, D}, 5);
    abort = 1;
    @(negedge clk);
    abort = 0;
    m = model(ea, eb, eg, 5, k);
    chk("abort_busy", busy, 0);
    chk("abort_abcd", {A, B, C, D}, 0);
    chk("abort_pass", pass, 0);
    chk("abort_res_alpha", res_alpha, m.ra);
    chk("abort_res_beta", res_beta, m.rb);
    chk("abort_res_gamma", res_gamma, m.rg);
    chk("abort_count", mismatch_count, m.cnt);
    ds = done_seen;
    repeat (100) @(negedge clk);
    chk("abort_no_done", done_seen - ds, 0);
    start_sweep(ea, eb, eg, 0);
    for (int j = 0; j < 9 * DWELL + 1; j++) @(negedge clk);
    chk("reset_at_idx9", {A, B, C, D}, 9);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("midrst_abcd", {A, B, C, D}, 0);
    chk("midrst_flags", {busy, done, pass, first_fail_valid}, 0);
    chk("midrst_count", {mismatch_count, first_fail_idx}, 0);
    chk("midrst_res", {res_alpha, res_beta, res_gamma}, 0);
    ua = 16'hAAAA;
    ub = 16'h8888;
    ug = 16'hFFF0;
    full_sweep(16'hAAAA, 16'h8888, 16'hFFF0);
    chk("queue_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
